// File: rtl/riscv_fetch.sv
// Instruction fetch stage: issues single-beat reads to instruction memory,
// tags returned words with their PC and queues them to decode in a small
// circular buffer. Taken branches flush the buffer and kill in-flight fetches.
module riscv_fetch #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [PC_SIZE-1:0]    if_next_addr_w,
  input  logic                  branch_taken_w,
  output logic                  ird,
  output logic                  imem_req_o,
  output logic [PC_SIZE-1:0]    imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [INSTR_SIZE-1:0] imem_data_i,
  output logic                  id_valid_o,
  output logic [INSTR_SIZE-1:0] id_instr_o,
  output logic [PC_SIZE-1:0]    id_pc_o,
  input  logic                  id_ready_i
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StKill} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [CntW-1:0]       r_count;
  logic [CntW-1:0]       w_count_next;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PC_SIZE-1:0]    r_req_pc;
  logic [INSTR_SIZE-1:0] r_instr_mem [BUF_DEPTH];
  logic [PC_SIZE-1:0]    r_pc_mem    [BUF_DEPTH];

  logic w_can_issue;
  logic w_pop;
  logic w_push;
  logic w_issue;

  // Issue decision: the count after this cycle's pop/push/flush must leave room
  // for the word the new request will return.
  always_comb begin
    w_can_issue = (r_state == StIdle) || ((r_state == StBusy) && imem_ack_i);
    w_pop       = id_valid_o & id_ready_i & ~branch_taken_w;
    w_push      = (r_state == StBusy) & imem_ack_i & ~branch_taken_w;
    if (branch_taken_w) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count - CntW'(w_pop) + CntW'(w_push);
    end
    // Reset is async, so gate issue while it is held to keep req/ird low.
    w_issue = w_can_issue && (w_count_next < CntW'(BUF_DEPTH)) && !reset_i;
  end

  // Next-state logic for the outstanding-request tracker.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_issue) w_state_next = StBusy;
      end
      StBusy: begin
        if (imem_ack_i) begin
          w_state_next = w_issue ? StBusy : StIdle;
        end else if (branch_taken_w) begin
          w_state_next = StKill;
        end
      end
      StKill: begin
        // The killed word is dropped; no issue in this cycle.
        if (imem_ack_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign ird         = w_issue;
  assign imem_req_o  = w_issue;
  assign imem_addr_o = if_next_addr_w;
  assign id_valid_o  = (r_count != '0);
  assign id_instr_o  = r_instr_mem[r_rd_ptr];
  assign id_pc_o     = r_pc_mem[r_rd_ptr];

  // Control state: FSM, occupancy, pointers and the tag of the live request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_issue) r_req_pc <= if_next_addr_w;
      if (branch_taken_w) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
    end
  end

  // Buffer storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_data_i;
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
    end
  end

endmodule
